// File: rtl/axis_lfsr_check.sv
// AXI-stream frame checker: regenerates the axis_gen LFSR sequence and compares
// it beat by beat, reporting mismatch count, first bad index and tlast framing errors.
module axis_lfsr_check #(
  parameter int          N     = 16,
  parameter int          DATAW = 64,
  parameter logic [63:0] SEED  = 64'hFEDCBA9876543210,
  parameter int          ADDRW = $clog2(N)
) (
  input  logic             clk,
  input  logic             arstn,
  input  logic             start,
  input  logic             hold,
  input  logic [DATAW-1:0] stream_in_tdata,
  input  logic             stream_in_tvalid,
  output logic             stream_in_tready,
  input  logic             stream_in_tlast,
  output logic [ADDRW:0]   err_count,
  output logic [ADDRW-1:0] first_err_idx,
  output logic             frame_err,
  output logic             done,
  output logic             pass
);

  localparam logic [63:0] FB_MASK = 64'hD800000000000000;

  typedef enum logic [1:0] {
    IDLE = 2'd0,
    RUN  = 2'd1,
    DONE = 2'd2
  } state_t;

  state_t           state;
  logic [63:0]      lfsr;
  logic [ADDRW-1:0] idx;

  logic             hs;
  logic             mism;
  logic             last_beat;
  logic             tlast_bad;
  logic [ADDRW:0]   err_nxt;
  logic             ferr_nxt;

  function automatic logic [63:0] lfsr_next(input logic [63:0] s);
    return (s >> 1) ^ (s[0] ? FB_MASK : 64'h0);
  endfunction

  function automatic logic [ADDRW:0] sat_inc(input logic [ADDRW:0] v);
    return (&v) ? v : v + 1'b1;
  endfunction

  // tready is combinational so an async reset drops it immediately
  assign stream_in_tready = (state == RUN) && !hold;

  always_comb begin
    hs        = stream_in_tvalid && stream_in_tready;
    mism      = stream_in_tdata != lfsr[DATAW-1:0];
    last_beat = idx == ADDRW'(N - 1);
    tlast_bad = last_beat ? !stream_in_tlast : stream_in_tlast;
    err_nxt   = mism ? sat_inc(err_count) : err_count;
    ferr_nxt  = frame_err || tlast_bad;
  end

  always_ff @(posedge clk or negedge arstn) begin
    if (!arstn) begin
      state         <= IDLE;
      lfsr          <= SEED;
      idx           <= '0;
      err_count     <= '0;
      first_err_idx <= '0;
      frame_err     <= 1'b0;
      done          <= 1'b0;
      pass          <= 1'b0;
    end else if (start) begin
      // start from any state re-arms; a beat accepted this cycle is dropped
      state         <= RUN;
      lfsr          <= SEED;
      idx           <= '0;
      err_count     <= '0;
      first_err_idx <= '0;
      frame_err     <= 1'b0;
      done          <= 1'b0;
      pass          <= 1'b0;
    end else begin
      case (state)
        RUN: begin
          if (hs) begin
            lfsr      <= lfsr_next(lfsr);
            err_count <= err_nxt;
            frame_err <= ferr_nxt;
            if (mism && (err_count == '0))
              first_err_idx <= idx;
            if (last_beat) begin
              state <= DONE;
              done  <= 1'b1;
              pass  <= (err_nxt == '0) && !ferr_nxt;
            end else begin
              idx <= idx + ADDRW'(1);
            end
          end
        end
        default: ;
      endcase
    end
  end

endmodule

// File: tb/tb_axis_lfsr_check.sv
// Scoreboard bench for axis_lfsr_check: drives LFSR frames with corruption,
// framing faults, back-pressure, re-arm and reset, plus a DATAW=1 instance.
module tb_axis_lfsr_check;

  localparam logic [63:0] SEED    = 64'hFEDCBA9876543210;
  localparam logic [63:0] FB_MASK = 64'hD800000000000000;

  logic        clk = 1'b0;
  logic        arstn;
  logic        start;
  logic        hold;
  logic [63:0] tdata;
  logic        tvalid;
  logic        tlast;
  logic        tready;
  logic [4:0]  err_count;
  logic [3:0]  first_err_idx;
  logic        frame_err;
  logic        done;
  logic        pass;

  logic        w1_tready;
  logic [4:0]  w1_err_count;
  logic [3:0]  w1_first_err_idx;
  logic        w1_frame_err;
  logic        w1_done;
  logic        w1_pass;

  int vectors     = 0;
  int miscompares = 0;

  typedef struct {
    logic [4:0] err;
    logic [3:0] first;
    logic       ferr;
    logic       pass;
  } exp_t;

  exp_t sb[$];

  always #5 clk = ~clk;

  axis_lfsr_check #(.N(16), .DATAW(64), .SEED(SEED)) dut (
    .clk(clk), .arstn(arstn), .start(start), .hold(hold),
    .stream_in_tdata(tdata), .stream_in_tvalid(tvalid),
    .stream_in_tready(tready), .stream_in_tlast(tlast),
    .err_count(err_count), .first_err_idx(first_err_idx),
    .frame_err(frame_err), .done(done), .pass(pass)
  );

  axis_lfsr_check #(.N(16), .DATAW(1), .SEED(SEED)) dut_w1 (
    .clk(clk), .arstn(arstn), .start(start), .hold(hold),
    .stream_in_tdata(tdata[0:0]), .stream_in_tvalid(tvalid),
    .stream_in_tready(w1_tready), .stream_in_tlast(tlast),
    .err_count(w1_err_count), .first_err_idx(w1_first_err_idx),
    .frame_err(w1_frame_err), .done(w1_done), .pass(w1_pass)
  );

  function automatic logic [63:0] lfsr_step(input logic [63:0] s);
    return (s >> 1) ^ (s[0] ? FB_MASK : 64'h0);
  endfunction

  task automatic check(input string tag, input logic [63:0] got, input logic [63:0] exp);
    vectors++;
    if (got !== exp) begin
      miscompares++;
      $display("FAIL %s: got %0h expected %0h", tag, got, exp);
    end
  endtask

  // Called #1 after a posedge; leaves the checker in RUN.
  task automatic arm();
    start  = 1'b1;
    tvalid = 1'b0;
    tlast  = 1'b0;
    hold   = 1'b0;
    @(posedge clk); #1;
    start  = 1'b0;
  endtask

  task automatic run_frame(input logic [15:0] corrupt_in, input logic [15:0] tl,
                           input bit bp, input int abort_in, input int rst_at,
                           input bit chk_w1);
    logic [15:0] corrupt = corrupt_in;
    int          abort_at = abort_in;
    logic [63:0] lf = SEED;
    int          beat = 0;
    int          cyc = 0;
    int          run_err = 0;
    bit          hs;
    exp_t        e;
    exp_t        got_e;

    if (rst_at < 0) begin
      logic [15:0] eff;
      eff     = (abort_at >= 0) ? 16'h0 : corrupt;
      e.err   = 5'($countones(eff));
      e.first = 4'd0;
      for (int i = 15; i >= 0; i--) if (eff[i]) e.first = 4'(i);
      e.ferr  = (tl != 16'h8000);
      e.pass  = (e.err == 0) && !e.ferr;
      sb.push_back(e);
    end

    while (beat < 16 && cyc < 2000) begin
      tvalid = bp ? ($urandom_range(0, 3) != 0) : 1'b1;
      hold   = bp ? (cyc % 3 == 0) : 1'b0;
      tdata  = lf ^ {63'h0, corrupt[beat]};
      tlast  = tl[beat];
      start  = (beat == abort_at);
      @(negedge clk);
      hs = tvalid && tready;
      if (hs) begin
        check("run_err", err_count, run_err);
        check("done_early", done, 0);
      end
      if (beat == rst_at) begin
        arstn = 1'b0;
        #1;
        check("rst_tready", tready, 0);
        check("rst_err", err_count, 0);
        check("rst_done", done, 0);
        tvalid = 1'b0;
        @(posedge clk); #1;
        arstn = 1'b1;
        @(posedge clk); #1;
        return;
      end
      @(posedge clk); #1;
      cyc++;
      if (start) begin
        start = 1'b0;
        check("abort_clr", err_count, 0);
        beat = 0; lf = SEED; corrupt = 16'h0; abort_at = -1; run_err = 0;
      end else if (hs) begin
        if (corrupt[beat]) run_err++;
        beat++;
        lf = lfsr_step(lf);
      end
    end
    check("frame_beats", beat, 16);
    tvalid = 1'b0;
    tlast  = 1'b0;
    hold   = 1'b0;
    check("done_rise", done, 1);

    if (sb.size() == 0) begin
      check("sb_empty", 1, 0);
    end else begin
      e = sb.pop_front();
      got_e.err  = err_count;
      got_e.ferr = frame_err;
      got_e.pass = pass;
      check("err_count", got_e.err, e.err);
      if (e.err != 0) check("first_err_idx", first_err_idx, e.first);
      check("frame_err", got_e.ferr, e.ferr);
      check("pass", got_e.pass, e.pass);
    end
    if (chk_w1) begin
      check("w1_err_count", w1_err_count, 1);
      check("w1_first_err_idx", w1_first_err_idx, 0);
      check("w1_pass", w1_pass, 0);
    end

    // beats offered in DONE must be ignored
    tvalid = 1'b1;
    tdata  = ~SEED;
    repeat (2) begin
      @(negedge clk);
      check("done_tready", tready, 0);
      @(posedge clk); #1;
    end
    tvalid = 1'b0;
    check("frozen_err", err_count, e.err);
    check("done_hold", done, 1);
  endtask

  initial begin
    arstn  = 1'b0;
    start  = 1'b0;
    hold   = 1'b0;
    tdata  = 64'h0;
    tvalid = 1'b0;
    tlast  = 1'b0;
    repeat (2) @(posedge clk);
    @(negedge clk);
    check("reset_tready", tready, 0);
    check("reset_err", err_count, 0);
    check("reset_done", done, 0);
    check("reset_pass", pass, 0);
    check("reset_ferr", frame_err, 0);
    arstn = 1'b1;
    @(posedge clk); #1;
    tvalid = 1'b1;
    @(negedge clk);
    check("idle_tready", tready, 0);
    @(posedge clk); #1;
    tvalid = 1'b0;

    arm(); run_frame(16'h0000, 16'h8000, 1'b0, -1, -1, 1'b0);  // loopback
    arm(); run_frame(16'h0208, 16'h8000, 1'b0, -1, -1, 1'b0);  // beats 3, 9 corrupt
    arm(); run_frame(16'h0000, 16'h8000, 1'b1, -1, -1, 1'b0);  // back-pressure
    arm(); run_frame(16'h0000, 16'h0080, 1'b0, -1, -1, 1'b0);  // early tlast, none at 15
    arm(); run_frame(16'h0008, 16'h8000, 1'b0,  5, -1, 1'b0);  // abort at beat 5
    arm(); run_frame(16'h0000, 16'h8000, 1'b0, -1, -1, 1'b0);  // re-arm from DONE
    arm(); run_frame(16'h0004, 16'h8000, 1'b0, -1, 10, 1'b0);  // reset at beat 10
    arm(); run_frame(16'h0000, 16'h8000, 1'b0, -1, -1, 1'b0);  // clean after reset
    arm(); run_frame(16'h0001, 16'h8000, 1'b0, -1, -1, 1'b1);  // beat 0 corrupt, DATAW=1 too

    check("sb_drained", sb.size(), 0);
    $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
    $finish;
  end

  initial begin
    #500000;
    $display("FAIL watchdog: got timeout expected completion");
    $fatal(1);
  end

endmodule

// File: doc/axis_lfsr_check.md
Name: axis_lfsr_check

Overview:
- Receiver counterpart of axis_gen.
- Consumes one AXI-stream frame of N beats, regenerates the same LFSR sequence from the same SEED, and compares it beat by beat.
- Reports mismatch count, first failing index, tlast framing errors and a pass/done summary.
- Sits at the end of a stream path in place of axisdump, either a loopback generator or a pass-through DUT, for self-checking hardware bring-up.

Parameters:
- N, 16, beats per frame; tlast is required on beat N-1 (N >= 2).
- DATAW, 64, compared tdata width (1..64).
- SEED, 64'hFEDCBA9876543210, LFSR seed; must equal the paired axis_gen SEED.
- ADDRW, $clog2(N), width of the index outputs.

Ports:
- clk  in  1  clock.
- arstn  in  1  asynchronous reset, active low.
- start  in  1  one-cycle pulse: arm a new frame check (reloads LFSR, clears stats).
- hold  in  1  when 1, deassert tready (back-pressure insertion for test).
- stream_in  axis_if slave  DATAW  tdata/tvalid/tready/tlast; tready is the only output.
- err_count  out  ADDRW+1  number of mismatching beats in the current/last frame.
- first_err_idx  out  ADDRW  index of the first mismatching beat; valid when err_count != 0.
- frame_err  out  1  tlast missing on beat N-1, or asserted early.
- done  out  1  frame completed; held until the next start.
- pass  out  1  done & err_count==0 & !frame_err.

Behaviour:
- Reset (arstn=0, async): state=IDLE, lfsr=SEED, idx=0, tready=0, err_count=0, first_err_idx=0, frame_err=0, done=0, pass=0.
- LFSR:
  - 64-bit Galois, right shift, feedback mask 64'hD800000000000000, identical to axis_gen.
  - Expected data = lfsr[DATAW-1:0].
  - Advances exactly once per accepted beat (tvalid & tready); otherwise holds.
- States:
  - IDLE: tready=0. On start, go to RUN with lfsr=SEED, idx=0 and all stats cleared, in that cycle.
  - RUN: tready = !hold, registered-free combinational from state and hold. Per accepted beat, in the same clock edge:
    - Compare tdata with expected; on mismatch, err_count saturating +1, and first_err_idx=idx if err_count was 0.
    - If idx==N-1 and !tlast, set frame_err. If idx<N-1 and tlast, set frame_err.
    - If idx==N-1: go to DONE. Else idx+1.
  - DONE: tready=0, done=1, pass valid; stats frozen. start returns to RUN (re-arm, clear) without passing through IDLE.
- Latency: stats for beat k are visible the cycle after its acceptance. done rises the cycle after the beat N-1 handshake.
- Early tlast does not end the frame; checking continues to N beats. Frame length is fixed by N, not by tlast.
- tvalid=0 or hold=1: no handshake, no LFSR step, no idx change. Stalls of any length are legal.
- start while in RUN (mid-frame): abort and re-arm; stats cleared, LFSR reloaded that cycle. A beat handshaked in that same cycle is discarded.
- err_count saturates at 2^(ADDRW+1)-1; it never wraps.
- Async reset mid-frame: immediate return to reset values; tready drops asynchronously.
- Beats accepted only in RUN; tvalid in IDLE/DONE is ignored (tready=0).

Test Plan:
- Loopback: axis_gen(SEED default, N=16, DATAW=64) to checker, start pulse → 16 handshakes, done=1 one cycle after beat 15, err_count=0, frame_err=0, pass=1.
- Corruption: flip bit 0 of tdata on beats 3 and 9 → err_count=2, first_err_idx=3, pass=0, frame_err=0.
- Back-pressure: hold toggled 1 every third cycle and random tvalid gaps → same result as the loopback test (pass=1). No beat is lost or duplicated; LFSR steps only on handshakes.
- Framing: tlast at beat 7 and absent at beat 15 → frame_err=1, done after the 16th beat, pass=0, err_count=0.
- Re-arm: start asserted at beat 5 of a corrupted frame, then a clean frame → stats cleared that cycle, final err_count=0, pass=1. A second start from DONE runs a further clean frame with pass=1.
- Reset: arstn low during beat 10 → tready=0, err_count=0, done=0 immediately. After release, start then a clean frame gives pass=1. DATAW=1 variant with a corrupted beat 0 gives first_err_idx=0, err_count=1.
